// File: rtl/ring_addresser.sv
// ring_addresser: circular-buffer address controller for an external simple
// dual-port RAM with one synchronous read port (one cycle read latency).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   wr_valid, wr_data   incoming word strobe and payload
//   rd_req              consumer request for the oldest stored word
//   flush               synchronous clear of pointers, count and flags
//   mem_we/waddr/wdata  RAM write command (registered)
//   mem_re/raddr        RAM read command (registered)
//   rd_valid            external RAM read data valid this cycle
//   count, empty, full  occupancy (0..DEPTH) and derived flags
//   overflow            sticky: a write was dropped or overwrote old data
//
// Optional build macro RING_ADDRESSER_OVERWRITE_EN: when defined, a write
// into a full buffer (no read in the same cycle) overwrites the oldest
// entry instead of being dropped.

module ring_addresser #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              flush,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    // DEPTH = 2**ADDR_W expressed at count width
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;

    logic              rd_acc_c;
    logic              wr_acc_c;
    logic              wr_lost_c;
    logic              ovw_c;
    logic [ADDR_W:0]   count_nxt_c;

    // Acceptance decisions and next occupancy
    always_comb begin
        rd_acc_c    = rd_req && !empty;
`ifdef RING_ADDRESSER_OVERWRITE_EN
        wr_acc_c    = wr_valid;
        ovw_c       = wr_valid && full && !rd_acc_c;
`else
        wr_acc_c    = wr_valid && (!full || rd_acc_c);
        ovw_c       = 1'b0;
`endif
        // Full with no read to make room: data is lost either way
        wr_lost_c   = wr_valid && full && !rd_acc_c;

        count_nxt_c = count;
        if (wr_acc_c && !rd_acc_c && !ovw_c) begin
            count_nxt_c = count + (ADDR_W+1)'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_nxt_c = count - (ADDR_W+1)'(1);
        end
    end

    // Pointers, RAM commands and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            rd_valid  <= 1'b0;
        end else if (flush) begin
            // RAM contents are left alone; an in-flight read is abandoned
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            mem_we <= wr_acc_c;
            if (wr_acc_c) begin
                mem_waddr <= wptr;
                mem_wdata <= wr_data;
                wptr      <= wptr + ADDR_W'(1);
            end

            mem_re <= rd_acc_c;
            if (rd_acc_c) begin
                mem_raddr <= rptr;
            end
            // Overwrite discards the oldest entry by skipping past it
            if (rd_acc_c || ovw_c) begin
                rptr <= rptr + ADDR_W'(1);
            end

            // RAM returns data one cycle after the read command
            rd_valid <= mem_re;

            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
            full  <= (count_nxt_c == DEPTH_CNT);

            if (wr_lost_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
